// File: rtl/pmem_burst_pkg.sv
// Shared definitions for the cache-line to memory-burst adaptor:
// FSM state encoding and default geometry constants.
package pmem_burst_pkg;

    localparam int unsigned LINE_WIDTH  = 256;
    localparam int unsigned BURST_WIDTH = 64;
    localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned BEAT_IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } pmem_adapt_state_t;

endpackage : pmem_burst_pkg

// File: rtl/pmem_line_adaptor.sv
// Responder for whole-line cache pmem requests; splits each line into
// BEATS bursts on a narrow memory bus (serialise on write, assemble on read).
module pmem_line_adaptor
    import pmem_burst_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp
);

    localparam int unsigned L_BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned L_IDX_W = (L_BEATS > 1) ? $clog2(L_BEATS) : 1;
    localparam int unsigned L_OFF_W = $clog2(LINE_WIDTH / 8);

    pmem_adapt_state_t r_state, w_next_state;

    logic [L_IDX_W-1:0]                   r_beat;
    logic [L_BEATS-1:0][BURST_WIDTH-1:0]  r_buf;
    logic [L_BEATS-1:0][BURST_WIDTH-1:0]  r_rdata;
    logic [L_BEATS-1:0][BURST_WIDTH-1:0]  w_buf_fill;
    logic [ADDR_WIDTH-1:0]                r_addr;
    logic                                 w_last_beat;
    logic                                 w_req;
    logic [L_OFF_W-1:0]                   w_unused_offset;

    assign w_last_beat     = (r_beat == L_IDX_W'(L_BEATS - 1));
    assign w_req           = pmem_read | pmem_write;
    assign w_unused_offset = pmem_address[L_OFF_W-1:0];

    // Buffer with the current read beat merged in, so the completing beat
    // can be published to pmem_rdata on the same edge it is captured.
    always_comb begin
        w_buf_fill         = r_buf;
        w_buf_fill[r_beat] = mem_rdata;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (pmem_write)
                    w_next_state = WR_BURST;
                else if (pmem_read)
                    w_next_state = RD_BURST;
            end
            RD_BURST: begin
                if (mem_resp && w_last_beat)
                    w_next_state = DONE;
            end
            WR_BURST: begin
                if (mem_resp && w_last_beat)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr <= {pmem_address[ADDR_WIDTH-1:L_OFF_W], {L_OFF_W{1'b0}}};
                        r_buf  <= pmem_wdata;
                        r_beat <= '0;
                    end
                end
                RD_BURST: begin
                    if (mem_resp) begin
                        r_buf <= w_buf_fill;
                        if (w_last_beat)
                            r_rdata <= w_buf_fill;
                        else
                            r_beat <= r_beat + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (mem_resp && !w_last_beat)
                        r_beat <= r_beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pmem_rdata  = r_rdata;
    assign pmem_resp   = (r_state == DONE);
    assign mem_read    = (r_state == RD_BURST);
    assign mem_write   = (r_state == WR_BURST);
    assign mem_address = r_addr;
    assign mem_wdata   = (r_state == WR_BURST) ? r_buf[r_beat] : '0;

endmodule : pmem_line_adaptor
